// File: rtl/pwm_multi_channel_gen.sv
// Purpose : N-channel PWM generator with a shared period counter and shadowed per-channel duty set by debounced buttons.
// Latency : PWM outputs lag the period counter by one clk; duty readback lags the shadow register by one clk.
// Backpressure: none; button events are dropped while ena=0, and out-of-range sel_ch values are ignored.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   ena               block enable (counter held at 0 and outputs forced low when 0)
//   sel_ch            channel targeted by the buttons and by uo_duty_rd
//   ui_increase_duty  raw push-button, raises the shadow duty of sel_ch by STEP
//   ui_decrease_duty  raw push-button, lowers the shadow duty of sel_ch by STEP
//   uo_pwm_out        registered PWM outputs, bit i = channel i
//   uo_duty_rd        registered shadow duty of sel_ch (0 when sel_ch is out of range)
//   uo_period_start   one-cycle pulse while the counter sits at 0 after a wrap
//
// Optional feature: define PWM_PHASE_STAGGER_EN to offset channel i's compare
// point by i*(PERIOD/NUM_CH) counts, spreading the rising edges over the period.

module pwm_multi_channel_gen #(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 8,
   parameter int PERIOD    = 10,
   parameter int STEP      = 1,
   parameter int INIT_DUTY = 5,
   parameter int DEB_DIV   = 12500000,
   localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [SEL_W-1:0]  sel_ch,
   input  logic              ui_increase_duty,
   input  logic              ui_decrease_duty,
   output logic [NUM_CH-1:0] uo_pwm_out,
   output logic [CNT_W-1:0]  uo_duty_rd,
   output logic              uo_period_start
);

   localparam int PS_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

   localparam logic [PS_W-1:0]  PS_MAX    = PS_W'(DEB_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W:0]   PERIOD_W  = (CNT_W+1)'(PERIOD);
   localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(STEP);
   localparam logic [CNT_W:0]   STEP_W    = (CNT_W+1)'(STEP);
   localparam logic [CNT_W-1:0] INIT_C    = CNT_W'(INIT_DUTY);
   localparam logic [SEL_W:0]   NUM_CH_C  = (SEL_W+1)'(NUM_CH);

   // State registers
   logic [PS_W-1:0]   ps_q, ps_d;
   logic [1:0]        s1_q, s1_d;            // bit0 = increase, bit1 = decrease
   logic [1:0]        s2_q, s2_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  shadow_q [NUM_CH];
   logic [CNT_W-1:0]  shadow_d [NUM_CH];
   logic [CNT_W-1:0]  active_q [NUM_CH];
   logic [CNT_W-1:0]  active_d [NUM_CH];
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic [CNT_W-1:0]  duty_rd_q, duty_rd_d;
   logic              pstart_q, pstart_d;

   // Combinational helpers
   logic              tick;
   logic [1:0]        ev;
   logic              sel_ok;
   logic              upd;
   logic              wrap;
   logic [CNT_W-1:0]  sel_duty;
   logic [CNT_W:0]    inc_sum;
   logic [CNT_W-1:0]  inc_val;
   logic [CNT_W-1:0]  dec_val;
`ifdef PWM_PHASE_STAGGER_EN
   logic [CNT_W:0]    ph;
`endif

   assign tick   = (ps_q == PS_MAX);
   // Rising edge of the sampled button, seen only on the sample tick so a
   // held button yields exactly one event.
   assign ev     = s1_q & ~s2_q & {2{tick}};
   assign sel_ok = ({1'b0, sel_ch} < NUM_CH_C);
   assign upd    = ena & sel_ok & (ev[0] ^ ev[1]);
   assign wrap   = ena & (cnt_q == CNT_MAX);

   assign sel_duty = sel_ok ? shadow_q[sel_ch] : '0;
   // One extra bit so saturation is decided before any wrap can occur.
   assign inc_sum  = {1'b0, sel_duty} + STEP_W;
   assign inc_val  = (inc_sum > PERIOD_W) ? PERIOD_C : inc_sum[CNT_W-1:0];
   assign dec_val  = (sel_duty < STEP_C) ? '0 : (sel_duty - STEP_C);

   always_comb begin
      ps_d      = tick ? '0 : (ps_q + 1'b1);
      s1_d      = tick ? {ui_decrease_duty, ui_increase_duty} : s1_q;
      s2_d      = tick ? s1_q : s2_q;
      cnt_d     = (!ena || wrap) ? '0 : (cnt_q + 1'b1);
      shadow_d  = shadow_q;
      // Active duty samples the pre-edge shadow, so a same-cycle shadow
      // write is picked up only at the following wrap.
      active_d  = wrap ? shadow_q : active_q;
      duty_rd_d = sel_duty;
      pstart_d  = wrap;
      pwm_d     = '0;
`ifdef PWM_PHASE_STAGGER_EN
      ph        = '0;
`endif
      if (upd) begin
         shadow_d[sel_ch] = ev[0] ? inc_val : dec_val;
      end
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
         // Offset is always < PERIOD, so one conditional subtract is a full mod.
         ph = {1'b0, cnt_q} + (CNT_W+1)'(i * (PERIOD / NUM_CH));
         if (ph >= PERIOD_W) begin
            ph = ph - PERIOD_W;
         end
         pwm_d[i] = ena & (ph[CNT_W-1:0] < active_q[i]);
`else
         pwm_d[i] = ena & (cnt_q < active_q[i]);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ps_q      <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         cnt_q     <= '0;
         pwm_q     <= '0;
         duty_rd_q <= INIT_C;
         pstart_q  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= INIT_C;
            active_q[i] <= INIT_C;
         end
      end else begin
         ps_q      <= ps_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         cnt_q     <= cnt_d;
         pwm_q     <= pwm_d;
         duty_rd_q <= duty_rd_d;
         pstart_q  <= pstart_d;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
      end
   end

   assign uo_pwm_out      = pwm_q;
   assign uo_duty_rd      = duty_rd_q;
   assign uo_period_start = pstart_q;

endmodule
